sent_rx_output_arbiter: RTL and testbench
=========================================

// Module: sent_rx_output_arbiter
// PURPOSE
//  Shares the RX output FIFO write port between decoded fast-channel words (store FIFO, 12b)
//  and validated slow-channel serial messages (8b ID + 16b data). It sits between the SENT RX
//  control path and the RX output FIFO. Serial messages go out atomically as 3 tagged words,
//  and fast traffic is round-robin bounded so serial messages are never starved.
// PARAMETERS
//  FAST_BURST  4  max consecutive fast words granted while a serial message is pending (>=1)
//  OVF_W       8  width of serial-drop counter (saturating)
// PORTS
//  clk_rx            in   1   single clock
//  reset_rx          in   1   asynchronous, active-low reset
//  fast_valid        in   1   store FIFO non-empty, fast_data valid (show-ahead)
//  fast_data         in   12  fast-channel word at store FIFO head
//  fast_pop          out  1   pop store FIFO; transfer = fast_valid & fast_pop
//  serial_valid      in   1   one-cycle strobe: new CRC-valid serial message
//  serial_id         in   8   message ID
//  serial_data       in   16  message data
//  serial_enhanced   in   1   1 = enhanced serial format (config bit)
//  fifo_afull        in   1   output FIFO has <=1 free entry
//  write_enable_rx   out  1   registered write strobe to output FIFO
//  data_to_fifo_rx   out  12  registered write data
//  word_type         out  2   00 fast, 01 serial header, 10 serial data hi, 11 serial data lo
//  serial_drop_cnt   out  OVF_W  messages dropped because the holding register was full
// BEHAVIOUR
//  - Reset: state IDLE, all outputs 0, holding register empty, burst counter 0, drop count 0.
//  - Serial holding register (1 deep): loads on serial_valid when empty. It empties in the cycle
//    the SER_LO word is issued. serial_valid while full, and not emptying that same cycle
//    -> message dropped and serial_drop_cnt += 1, saturating at all-ones. serial_valid in the
//    same cycle it empties -> the new message loads.
//  - Grant happens only when !fifo_afull. Output is registered: the granted word appears with
//    write_enable_rx=1 exactly 1 cycle after the grant. write_enable_rx is 0 in all other cycles.
//  - FSM states: IDLE, SER_HDR, SER_HI, SER_LO.
//    IDLE: if hold_full and (!fast_valid or burst==FAST_BURST) -> issue header, go SER_HDR.
//          Else if fast_valid -> fast_pop=1, issue {fast_data, type 00}, burst+=1 (saturates at
//          FAST_BURST) when hold_full, else burst held 0.
//    SER_HDR: issue hi word -> SER_HI.  SER_HI: issue lo word -> SER_LO.
//    SER_LO: clear hold, burst=0 -> IDLE.
//    Issue in any state is stalled (state held, no pop, no write) while fifo_afull=1.
//  - Serial word packing:
//    hdr = {2'b00, serial_enhanced, 1'b0, id[7:0]}
//    hi  = {4'h0, data[15:8]}
//    lo  = {4'h0, data[7:0]}
//  - A serial message is never interleaved with fast words. fast_pop=0 outside IDLE.
//  - Reset asserted mid-message aborts the message: the partial message is discarded, and no
//    completion is required.
// STRUCTURE
//  - Shared package sent_rx_pkg: word_type encodings (WT_FAST, WT_SER_HDR, WT_SER_HI, WT_SER_LO)
//    and the FSM state enum.
//  - One sub-module is natural: sent_rx_serial_hold (1-deep holding register + drop counter).
//    The FSM and the output register stay in the top.
// TESTING
//  1 Reset: hold reset_rx=0 with fast_valid=1 -> write_enable_rx=0, fast_pop=0, drop_cnt=0
//    throughout.
//  2 Fast only: 5 words 0x001..0x005, afull=0 -> 5 consecutive writes, type 00, in order,
//    1-cycle latency.
//  3 Serial only: id=0xA5, data=0x1234, enh=1 -> writes 0x2A5, 0x012, 0x034, types 01, 10, 11,
//    on back-to-back cycles.
//  4 Fairness: fast stream continuous, serial arrives -> at most 4 fast words, then the
//    3 serial words uninterrupted, then fast resumes.
//  5 Backpressure: afull=1 during SER_HI -> no write while asserted. Release -> hi then lo,
//    data intact.
//  6 Drop: 2 serial strobes while the holding register is full and stalled -> drop_cnt=2.
//    Saturation check with OVF_W=2: 5 drops -> drop_cnt=3.

Source files
------------

// File: rtl/sent_rx_pkg.sv
// Shared SENT RX definitions: output word tags and arbiter FSM states.
package sent_rx_pkg;

    typedef enum logic [1:0] {
        WT_FAST    = 2'b00,
        WT_SER_HDR = 2'b01,
        WT_SER_HI  = 2'b10,
        WT_SER_LO  = 2'b11
    } word_type_t;

    typedef enum logic [1:0] {
        IDLE,
        SER_HDR,
        SER_HI,
        SER_LO
    } arb_state_t;

endpackage

// File: rtl/sent_rx_serial_hold.sv
// One-deep holding register for validated serial messages, with a saturating drop counter.
module sent_rx_serial_hold
    import sent_rx_pkg::*;
#(
    parameter int unsigned OVF_W = 8
) (
    input  logic             clk_rx,
    input  logic             reset_rx,
    input  logic             serial_valid,
    input  logic [7:0]       serial_id,
    input  logic [15:0]      serial_data,
    input  logic             serial_enhanced,
    input  logic             hold_clear,
    output logic             hold_full,
    output logic [7:0]       hold_id,
    output logic [15:0]      hold_data,
    output logic             hold_enh,
    output logic [OVF_W-1:0] serial_drop_cnt
);

    logic do_load;
    logic do_drop;

    // A message arriving in the cycle the last word is issued replaces the old one.
    assign do_load = serial_valid && (!hold_full || hold_clear);
    assign do_drop = serial_valid && hold_full && !hold_clear;

    always_ff @(posedge clk_rx or negedge reset_rx) begin
        if (!reset_rx) begin
            hold_full       <= 1'b0;
            hold_id         <= '0;
            hold_data       <= '0;
            hold_enh        <= 1'b0;
            serial_drop_cnt <= '0;
        end else begin
            if (do_load) begin
                hold_full <= 1'b1;
                hold_id   <= serial_id;
                hold_data <= serial_data;
                hold_enh  <= serial_enhanced;
            end else if (hold_clear) begin
                hold_full <= 1'b0;
            end
            if (do_drop && (serial_drop_cnt != '1)) begin
                serial_drop_cnt <= serial_drop_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sent_rx_output_arbiter.sv
// Arbitrates the RX output FIFO write port between fast-channel words and atomic
// 3-word serial messages, bounding fast bursts while a serial message waits.
module sent_rx_output_arbiter
    import sent_rx_pkg::*;
#(
    parameter int unsigned FAST_BURST = 4,
    parameter int unsigned OVF_W      = 8
) (
    input  logic             clk_rx,
    input  logic             reset_rx,
    input  logic             fast_valid,
    input  logic [11:0]      fast_data,
    output logic             fast_pop,
    input  logic             serial_valid,
    input  logic [7:0]       serial_id,
    input  logic [15:0]      serial_data,
    input  logic             serial_enhanced,
    input  logic             fifo_afull,
    output logic             write_enable_rx,
    output logic [11:0]      data_to_fifo_rx,
    output logic [1:0]       word_type,
    output logic [OVF_W-1:0] serial_drop_cnt
);

    localparam int unsigned BURST_W = $clog2(FAST_BURST + 1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(FAST_BURST);

    arb_state_t         state, state_nxt;
    logic [BURST_W-1:0] burst, burst_nxt;
    logic               grant_ok;
    logic               issue;
    logic [11:0]        word_nxt;
    word_type_t         type_nxt;
    logic               hold_clear;
    logic               hold_full;
    logic [7:0]         hold_id;
    logic [15:0]        hold_data;
    logic               hold_enh;

    sent_rx_serial_hold #(
        .OVF_W(OVF_W)
    ) u_hold (
        .clk_rx         (clk_rx),
        .reset_rx       (reset_rx),
        .serial_valid   (serial_valid),
        .serial_id      (serial_id),
        .serial_data    (serial_data),
        .serial_enhanced(serial_enhanced),
        .hold_clear     (hold_clear),
        .hold_full      (hold_full),
        .hold_id        (hold_id),
        .hold_data      (hold_data),
        .hold_enh       (hold_enh),
        .serial_drop_cnt(serial_drop_cnt)
    );

    // Gating with reset keeps fast_pop quiet while the block is held in reset.
    assign grant_ok = reset_rx && !fifo_afull;

    always_comb begin
        state_nxt  = state;
        burst_nxt  = burst;
        fast_pop   = 1'b0;
        issue      = 1'b0;
        word_nxt   = '0;
        type_nxt   = WT_FAST;
        hold_clear = 1'b0;
        unique case (state)
            IDLE: begin
                if (grant_ok) begin
                    if (hold_full && (!fast_valid || (burst == BURST_MAX))) begin
                        issue     = 1'b1;
                        word_nxt  = {2'b00, hold_enh, 1'b0, hold_id};
                        type_nxt  = WT_SER_HDR;
                        state_nxt = SER_HDR;
                    end else if (fast_valid) begin
                        fast_pop = 1'b1;
                        issue    = 1'b1;
                        word_nxt = fast_data;
                        type_nxt = WT_FAST;
                        if (!hold_full) begin
                            burst_nxt = '0;
                        end else if (burst != BURST_MAX) begin
                            burst_nxt = burst + 1'b1;
                        end
                    end
                end
            end
            SER_HDR: begin
                if (grant_ok) begin
                    issue     = 1'b1;
                    word_nxt  = {4'h0, hold_data[15:8]};
                    type_nxt  = WT_SER_HI;
                    state_nxt = SER_HI;
                end
            end
            SER_HI: begin
                if (grant_ok) begin
                    issue      = 1'b1;
                    word_nxt   = {4'h0, hold_data[7:0]};
                    type_nxt   = WT_SER_LO;
                    hold_clear = 1'b1;
                    state_nxt  = SER_LO;
                end
            end
            SER_LO: begin
                burst_nxt = '0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_rx or negedge reset_rx) begin
        if (!reset_rx) begin
            state           <= IDLE;
            burst           <= '0;
            write_enable_rx <= 1'b0;
            data_to_fifo_rx <= '0;
            word_type       <= '0;
        end else begin
            state           <= state_nxt;
            burst           <= burst_nxt;
            write_enable_rx <= issue;
            if (issue) begin
                data_to_fifo_rx <= word_nxt;
                word_type       <= type_nxt;
            end
        end
    end

endmodule

// File: tb/tb_sent_rx_output_arbiter.sv
// Directed bench for sent_rx_output_arbiter: vector table plus multi-cycle sequences.
module tb_sent_rx_output_arbiter;

    logic        clk_rx = 1'b0;
    logic        reset_rx;
    logic        fast_valid;
    logic [11:0] fast_data;
    logic        serial_valid;
    logic [7:0]  serial_id;
    logic [15:0] serial_data;
    logic        serial_enhanced;
    logic        fifo_afull;

    logic        fast_pop, fast_pop_s;
    logic        write_enable_rx, write_enable_s;
    logic [11:0] data_to_fifo_rx, data_s;
    logic [1:0]  word_type, word_type_s;
    logic [7:0]  serial_drop_cnt;
    logic [1:0]  serial_drop_cnt_s;

    int checks = 0;
    int errors = 0;

    always #5 clk_rx = ~clk_rx;

    sent_rx_output_arbiter #(
        .FAST_BURST(4),
        .OVF_W     (8)
    ) dut (
        .clk_rx         (clk_rx),
        .reset_rx       (reset_rx),
        .fast_valid     (fast_valid),
        .fast_data      (fast_data),
        .fast_pop       (fast_pop),
        .serial_valid   (serial_valid),
        .serial_id      (serial_id),
        .serial_data    (serial_data),
        .serial_enhanced(serial_enhanced),
        .fifo_afull     (fifo_afull),
        .write_enable_rx(write_enable_rx),
        .data_to_fifo_rx(data_to_fifo_rx),
        .word_type      (word_type),
        .serial_drop_cnt(serial_drop_cnt)
    );

    sent_rx_output_arbiter #(
        .FAST_BURST(4),
        .OVF_W     (2)
    ) dut_sat (
        .clk_rx         (clk_rx),
        .reset_rx       (reset_rx),
        .fast_valid     (fast_valid),
        .fast_data      (fast_data),
        .fast_pop       (fast_pop_s),
        .serial_valid   (serial_valid),
        .serial_id      (serial_id),
        .serial_data    (serial_data),
        .serial_enhanced(serial_enhanced),
        .fifo_afull     (fifo_afull),
        .write_enable_rx(write_enable_s),
        .data_to_fifo_rx(data_s),
        .word_type      (word_type_s),
        .serial_drop_cnt(serial_drop_cnt_s)
    );

    typedef struct {
        logic        fv;
        logic [11:0] fd;
        logic        sv;
        logic [7:0]  sid;
        logic [15:0] sdat;
        logic        enh;
        logic        afull;
        logic        exp_pop;
        logic        exp_we;
        logic [11:0] exp_data;
        logic [1:0]  exp_type;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic fv, input logic [11:0] fd, input logic sv,
                                input logic [7:0] sid, input logic [15:0] sdat, input logic enh,
                                input logic afull, input logic exp_pop, input logic exp_we,
                                input logic [11:0] exp_data, input logic [1:0] exp_type);
        vec_t v;
        v.fv = fv; v.fd = fd; v.sv = sv; v.sid = sid; v.sdat = sdat; v.enh = enh;
        v.afull = afull; v.exp_pop = exp_pop; v.exp_we = exp_we;
        v.exp_data = exp_data; v.exp_type = exp_type;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fv, input logic [11:0] fd, input logic sv,
                         input logic [7:0] sid, input logic [15:0] sdat, input logic enh,
                         input logic afull);
        fast_valid = fv; fast_data = fd; serial_valid = sv;
        serial_id = sid; serial_data = sdat; serial_enhanced = enh; fifo_afull = afull;
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled at the same offset.
    task automatic next_cycle();
        @(posedge clk_rx);
        #1;
    endtask

    logic [11:0] fdata;
    logic        pop_seen;
    logic        fr_we  [16];
    logic [11:0] fr_dat [16];
    logic [1:0]  fr_typ [16];
    logic        fr_pop [16];

    initial begin
        drive(1'b1, 12'h0AB, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0);
        reset_rx = 1'b0;

        // Reset held with fast traffic offered: nothing may be popped or written.
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("reset_pop", fast_pop, 1'b0);
            next_cycle();
            chk("reset_we", write_enable_rx, 1'b0);
            chk("reset_drop", serial_drop_cnt, 8'd0);
        end
        chk("reset_type", word_type, 2'b00);
        chk("reset_data", data_to_fifo_rx, 12'h000);
        fast_valid = 1'b0;
        reset_rx   = 1'b1;

        // Fast only.
        for (int k = 1; k <= 5; k++) begin
            vecs.push_back(mk(1'b1, 12'(k), 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0,
                              1'b1, 1'b1, 12'(k), 2'b00));
        end
        vecs.push_back(mk(1'b0, 12'h000, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 2'b00));
        // Serial only; a second message arrives the cycle the lo word goes out.
        vecs.push_back(mk(1'b0, 12'h000, 1'b1, 8'hA5, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 2'b00));
        vecs.push_back(mk(1'b0, 12'h000, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 12'h2A5, 2'b01));
        vecs.push_back(mk(1'b1, 12'h7FF, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 12'h012, 2'b10));
        vecs.push_back(mk(1'b1, 12'h7FF, 1'b1, 8'h5A, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b1, 12'h034, 2'b11));
        vecs.push_back(mk(1'b1, 12'h7FF, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 2'b00));
        vecs.push_back(mk(1'b0, 12'h000, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 12'h05A, 2'b01));
        vecs.push_back(mk(1'b0, 12'h000, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 12'h0BE, 2'b10));
        vecs.push_back(mk(1'b0, 12'h000, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 12'h0EF, 2'b11));
        vecs.push_back(mk(1'b0, 12'h000, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 2'b00));
        vecs.push_back(mk(1'b0, 12'h000, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 2'b00));
        // Backpressure before the hi word and again before the lo word.
        vecs.push_back(mk(1'b0, 12'h000, 1'b1, 8'h77, 16'hC3E1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 2'b00));
        vecs.push_back(mk(1'b0, 12'h000, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 12'h277, 2'b01));
        for (int k = 0; k < 3; k++) begin
            vecs.push_back(mk(1'b0, 12'h000, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 2'b00));
        end
        vecs.push_back(mk(1'b0, 12'h000, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 12'h0C3, 2'b10));
        vecs.push_back(mk(1'b0, 12'h000, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 2'b00));
        vecs.push_back(mk(1'b0, 12'h000, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 12'h0E1, 2'b11));
        vecs.push_back(mk(1'b0, 12'h000, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 2'b00));
        vecs.push_back(mk(1'b1, 12'h555, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 2'b00));
        vecs.push_back(mk(1'b1, 12'h555, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 12'h555, 2'b00));
        vecs.push_back(mk(1'b0, 12'h000, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 2'b00));

        foreach (vecs[i]) begin
            drive(vecs[i].fv, vecs[i].fd, vecs[i].sv, vecs[i].sid, vecs[i].sdat,
                  vecs[i].enh, vecs[i].afull);
            #1;
            chk($sformatf("vec%0d_pop", i), fast_pop, vecs[i].exp_pop);
            @(posedge clk_rx);
            #1;
            chk($sformatf("vec%0d_we", i), write_enable_rx, vecs[i].exp_we);
            if (vecs[i].exp_we) begin
                chk($sformatf("vec%0d_data", i), data_to_fifo_rx, vecs[i].exp_data);
                chk($sformatf("vec%0d_type", i), word_type, vecs[i].exp_type);
            end
            chk($sformatf("vec%0d_drop", i), serial_drop_cnt, 8'd0);
        end

        // Fairness: continuous fast stream from a modelled store FIFO, serial strobe in cycle 3.
        fdata = 12'h100;
        for (int c = 0; c < 16; c++) begin
            drive(1'b1, fdata, (c == 3), 8'h3C, 16'hA55A, 1'b0, 1'b0);
            #1;
            pop_seen = fast_pop;
            fr_pop[c] = pop_seen;
            @(posedge clk_rx);
            if (pop_seen) fdata = fdata + 12'h001;
            #1;
            fr_we[c]  = write_enable_rx;
            fr_dat[c] = data_to_fifo_rx;
            fr_typ[c] = word_type;
        end
        drive(1'b0, 12'h000, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0);
        for (int c = 0; c < 16; c++) begin
            if (c < 8) begin
                chk($sformatf("fair%0d_pop", c), fr_pop[c], 1'b1);
                chk($sformatf("fair%0d_we", c), fr_we[c], 1'b1);
                chk($sformatf("fair%0d_data", c), fr_dat[c], 12'h100 + 12'(c));
                chk($sformatf("fair%0d_type", c), fr_typ[c], 2'b00);
            end else if (c >= 12) begin
                chk($sformatf("fair%0d_pop", c), fr_pop[c], 1'b1);
                chk($sformatf("fair%0d_we", c), fr_we[c], 1'b1);
                chk($sformatf("fair%0d_data", c), fr_dat[c], 12'h108 + 12'(c - 12));
                chk($sformatf("fair%0d_type", c), fr_typ[c], 2'b00);
            end else begin
                chk($sformatf("fair%0d_pop", c), fr_pop[c], 1'b0);
            end
        end
        chk("fair_hdr_we", fr_we[8], 1'b1);
        chk("fair_hdr", {fr_typ[8], fr_dat[8]}, {2'b01, 12'h03C});
        chk("fair_hi_we", fr_we[9], 1'b1);
        chk("fair_hi", {fr_typ[9], fr_dat[9]}, {2'b10, 12'h0A5});
        chk("fair_lo_we", fr_we[10], 1'b1);
        chk("fair_lo", {fr_typ[10], fr_dat[10]}, {2'b11, 12'h05A});
        chk("fair_gap_we", fr_we[11], 1'b0);

        // Drops while the holding register is full and the output is stalled.
        next_cycle();
        drive(1'b0, 12'h000, 1'b1, 8'h11, 16'h2233, 1'b0, 1'b1);
        next_cycle();
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 12'h000, 1'b1, 8'hEE, 16'hFFFF, 1'b1, 1'b1);
            next_cycle();
            chk("drop_stall_we", write_enable_rx, 1'b0);
        end
        serial_valid = 1'b0;
        next_cycle();
        chk("drop_cnt_2", serial_drop_cnt, 8'd2);
        chk("drop_cnt_2_w2", serial_drop_cnt_s, 2'd2);
        for (int k = 0; k < 3; k++) begin
            serial_valid = 1'b1;
            next_cycle();
            serial_valid = 1'b0;
            next_cycle();
        end
        chk("drop_cnt_5", serial_drop_cnt, 8'd5);
        chk("drop_cnt_sat_w2", serial_drop_cnt_s, 2'd3);

        // Drain: the held message is the first one, untouched by the dropped ones.
        fifo_afull = 1'b0;
        next_cycle();
        chk("drain_hdr", {write_enable_rx, word_type, data_to_fifo_rx}, {1'b1, 2'b01, 12'h011});
        next_cycle();
        chk("drain_hi", {write_enable_rx, word_type, data_to_fifo_rx}, {1'b1, 2'b10, 12'h022});
        next_cycle();
        chk("drain_lo", {write_enable_rx, word_type, data_to_fifo_rx}, {1'b1, 2'b11, 12'h033});
        next_cycle();
        chk("drain_end_we", write_enable_rx, 1'b0);

        // Reset in mid-message discards it.
        drive(1'b0, 12'h000, 1'b1, 8'h42, 16'h9876, 1'b0, 1'b0);
        next_cycle();
        serial_valid = 1'b0;
        next_cycle();
        chk("abort_hdr_we", write_enable_rx, 1'b1);
        reset_rx = 1'b0;
        #1;
        chk("abort_we", write_enable_rx, 1'b0);
        next_cycle();
        reset_rx = 1'b1;
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            chk("abort_idle_we", write_enable_rx, 1'b0);
        end
        chk("abort_drop", serial_drop_cnt, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
